quad_enc_speed: RTL
===================

# quad_enc_speed

- Front end of the motor speed loop.
- Decodes the quadrature encoder channels A/B with a 4x edge decoder and accumulates signed counts over a fixed sample window.
- At the end of each window, publishes the saturated signed count as `enc`, a two's-complement speed for the PID stage.
- The window matches the PID update period, 55610 clocks ≈ 1.5 ms, so one fresh speed sample is ready per PID update.

## Interface

Parameters:
- `N` — default 8 — width of the speed output `enc` (two's complement).
- `WINDOW` — default 55610 — sample window length in clocks, ≥ 4.
- `FILT` — default 3 — glitch-filter length in clocks, ≥ 1.
- `ACC_W` — default 18 — internal accumulator width, signed. Must hold ±WINDOW.

Ports (clock and reset first):
- `clk` — in — 1 — system clock. All state is on the rising edge.
- `rst_n` — in — 1 — reset, asynchronous and active-low.
- `enc_a` — in — 1 — encoder channel A. Asynchronous to `clk`.
- `enc_b` — in — 1 — encoder channel B. Asynchronous to `clk`.
- `enc` — out — N — signed count of the last completed window, saturated.
- `valid` — out — 1 — one-cycle pulse when `enc` updates.
- `dir` — out — 1 — sign of the last window: 1 = negative (reverse), 0 otherwise.
- `err` — out — 1 — the last window saw at least one illegal A/B transition.

## Operation

- **Synchronizer:** two flip-flop stages per channel, giving `s_ab` = {A, B}.
- **Glitch filter:**
  - A stability counter restarts whenever `s_ab` changes.
  - The filtered state `f_ab` takes `s_ab` once `s_ab` has held a value different from `f_ab` for FILT consecutive cycles.
  - Pulses shorter than FILT cycles are never seen downstream.
- **Init after reset:**
  - An `armed` flag is 0 at reset.
  - The first filtered acceptance loads `f_ab` and sets `armed` without producing a step.
  - This prevents a spurious count when the pins rest at a nonzero state.
- **Decoder,** evaluated on each `f_ab` update from old value to new value:
  - Forward sequence 00→01→11→10→00: step = +1.
  - Reverse sequence: step = −1.
  - Both bits changed: step = 0, and the window's error flag is set.
- **Accumulator:**
  - Signed, ACC_W bits, updated as acc ← acc + step.
  - It cannot overflow for legal WINDOW/ACC_W, because at most one step is possible per clock.
- **Window counter:**
  - `wcnt` counts 0..WINDOW−1, then wraps.
  - At `wcnt` == WINDOW−1 it closes the window.
- **Window close:**
  - `total` = acc + step of that cycle. A step on the closing cycle belongs to the closing window.
  - `enc` ← saturate(`total`) to [−2^(N−1), 2^(N−1)−1].
  - `dir` ← `total` < 0.
  - `err` ← window error flag OR illegal transition on the closing cycle.
  - `valid` ← 1.
  - acc ← 0 and the window error flag ← 0, so the next window starts clean.
- `enc`, `dir`, and `err` hold their values between closes.

## Timing

- **Reset (asynchronous, immediate):**
  - Outputs: `enc` = 0, `valid` = 0, `dir` = 0, `err` = 0.
  - Internal: acc = 0, `wcnt` = 0, sync and filter registers = 0, `armed` = 0.
- **Pin-to-accumulator latency:** 2 + FILT rising edges. For FILT = 3, a pin change set up before edge k reaches acc at edge k+4.
- **First close after reset release:** the first `valid` pulse occurs on the WINDOW-th rising edge after `rst_n` deasserts.
- **Valid cadence:** thereafter, `valid` pulses every WINDOW clocks, high for exactly 1 cycle. The new `enc` is visible in the same cycle as `valid`.
- **Reset mid-window:** the partial count is discarded and no `valid` is issued. Windowing restarts from `wcnt` = 0.
- **Maximum input rate:** one filtered edge per FILT+1 clocks. Faster inputs are attenuated by the filter; this is accepted behaviour and is not flagged.

## Test plan

- **Forward rotation:**
  - Stimulus: after reset with pins at 00, drive the forward Gray sequence, 100 edges per window, with a 50-clock edge spacing.
  - Required response: `enc` = 100 (0x64), `dir` = 0, `err` = 0, and `valid` for 1 cycle every 55610 clocks.
- **Reverse plus saturation:**
  - Stimulus: 200 reverse edges in one window.
  - Required response: `enc` = −128 (0x80), `dir` = 1.
  - Follow-up: the next window with 0 edges gives `enc` = 0.
- **Illegal transition:**
  - Stimulus: step `f_ab` from 00 directly to 11 mid-window, then 10 legal forward edges.
  - Required response: `enc` = 10, `err` = 1. The following clean window gives `err` = 0.
- **Glitch rejection:**
  - Stimulus: 2-clock pulses on `enc_a` (FILT = 3).
  - Required response: acc unchanged and `enc` = 0.
  - Follow-up: a 3-clock hold is counted as exactly 1 step.
- **Boundary:**
  - Stimulus: time a forward edge so that it updates acc on the `wcnt` = WINDOW−1 cycle.
  - Required response: the edge is counted in the closing window, and the next window starts at 0.
- **Reset and init:**
  - Stimulus A: assert `rst_n` low mid-window with acc = 40. Required response: all outputs 0 immediately, and no `valid` until WINDOW clocks after release.
  - Stimulus B: hold the pins at 10 through reset release. Required response: the first window gives `enc` = 0.

Source files
------------

// File: rtl/quad_enc_speed.sv
// quad_enc_speed: 4x quadrature decoder with glitch filter, windowed signed count and saturated speed output.
module quad_enc_speed #(
    parameter int N      = 8,
    parameter int WINDOW = 55610,
    parameter int FILT   = 3,
    parameter int ACC_W  = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_a,
    input  logic         enc_b,
    output logic [N-1:0] enc,
    output logic         valid,
    output logic         dir,
    output logic         err
);
    localparam int CW = $clog2(FILT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (N - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (N - 1)));
    localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);

    logic [1:0]              sync1_q, sync1_d, s_ab_q, s_ab_d, f_ab_q, f_ab_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    armed_q, armed_d, werr_q, werr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, step, total;
    logic [WW-1:0]           wcnt_q, wcnt_d;
    logic [N-1:0]            enc_q, enc_d;
    logic                    valid_q, valid_d, dir_q, dir_d, err_q, err_d;
    logic                    pend, accept, mv, bad, close;
    logic [1:0]              dp;

    always_comb begin
        sync1_d = {enc_a, enc_b};
        s_ab_d  = sync1_q;
        // Until armed, the resting pin state is itself the pending value, so it gets accepted once without a step.
        pend    = !armed_q || (s_ab_q != f_ab_q);
        accept  = pend && (cnt_q == CW'(FILT - 1));
        cnt_d   = (accept || !pend || (sync1_q != s_ab_q)) ? '0 : cnt_q + 1'b1;
        f_ab_d  = accept ? s_ab_q : f_ab_q;
        armed_d = armed_q | accept;
        dp      = {s_ab_q[1], ^s_ab_q} - {f_ab_q[1], ^f_ab_q};
        mv      = accept && armed_q;
        step    = !mv ? '0 : (dp == 2'd1) ? ONE : (dp == 2'd3) ? -ONE : '0;
        bad     = mv && (dp == 2'd2);
        total   = acc_q + step;
        close   = wcnt_q == WW'(WINDOW - 1);
        wcnt_d  = close ? '0 : wcnt_q + 1'b1;
        acc_d   = close ? '0 : total;
        werr_d  = !close && (werr_q || bad);
        enc_d   = !close ? enc_q : (total > SAT_HI) ? SAT_HI[N-1:0] :
                  (total < SAT_LO) ? SAT_LO[N-1:0] : total[N-1:0];
        dir_d   = close ? total[ACC_W-1] : dir_q;
        err_d   = close ? (werr_q || bad) : err_q;
        valid_d = close;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            s_ab_q  <= '0;
            f_ab_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            werr_q  <= 1'b0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            enc_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            s_ab_q  <= s_ab_d;
            f_ab_q  <= f_ab_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            werr_q  <= werr_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            enc_q   <= enc_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign enc   = enc_q;
    assign valid = valid_q;
    assign dir   = dir_q;
    assign err   = err_q;
endmodule
